imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount, CSR zimm) to XLEN bits and flags illegal or unknown opcodes. Results, together with a caller tag (typically the PC), are stored in a 2-entry skid FIFO. Valid/ready handshakes on both sides. Sits between instruction fetch and the decode/execute stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets immediate width and shamt width (5 or 6 bits).
TAG_W, 32, width of the opaque tag carried alongside each instruction.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
flush_i  in  1  synchronous flush; discards all buffered entries.
in_valid_i  in  1  instruction/tag present.
in_ready_o  out  1  block can accept; depends only on state, not on out_ready_i.
instr_i  in  32  raw instruction word.
tag_i  in  TAG_W  caller tag, passed through unchanged.
out_valid_o  out  1  head entry valid.
out_ready_i  in  1  consumer accepts head entry.
imm_o  out  XLEN  decoded immediate of head entry.
fmt_o  out  3  format of head: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSRZ.
illegal_o  out  1  head instruction has an unsupported opcode.
tag_o  out  TAG_W  tag of head entry.

Behaviour:
- Decode is combinational on instr_i, keyed on opcode[6:2]. sign = instr[31]. Sign extension is to XLEN unless stated otherwise.
  - 00000 LOAD, 00011 MISC-MEM, 11001 JALR: I = sext(instr[31:20]).
  - 00100 OP-IMM: funct3 001/101 -> SHAMT = zext(instr[20+SH-1:20]), SH=5 for XLEN 32, SH=6 for XLEN 64. Other funct3 -> I.
  - 00110 OP-IMM-32: legal only when XLEN=64. funct3 001/101 -> SHAMT with 5 bits. Other funct3 -> I. When XLEN=32 -> illegal.
  - 01000 STORE: S = sext({instr[31:25], instr[11:7]}).
  - 11000 BRANCH: B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 00101 AUIPC, 01101 LUI: U = sext({instr[31:12], 12'b0}).
  - 11011 JAL: J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 11100 SYSTEM: funct3[2]=1 -> CSRZ = zext(instr[19:15]). funct3 001..011 -> I = zext(instr[31:20]) (CSR address). funct3 000 -> NONE.
  - 01100 OP, 01110 OP-32 (XLEN 64 only): NONE.
  - Any other opcode, or instr[1:0] != 2'b11: illegal=1, fmt NONE.
  - Whenever fmt is NONE, imm = 0.
- Storage: 2-entry FIFO with occupancy count 0..2. Each entry holds {imm, fmt, illegal, tag}.
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = (count != 2). out_valid_o = (count != 0). Outputs are always driven from the head entry registers.
- Latency: an instruction accepted in cycle N appears on outputs in cycle N+1 when the FIFO was empty.
- Push+pop at count 1: count stays 1; the new entry becomes head on the next cycle. At count 2 no push is possible. Push+pop at count 0 is impossible.
- Order is strictly FIFO. The head stays stable while out_valid_o=1 and out_ready_i=0.
- flush_i=1: count <- 0 on the next edge. A simultaneous push is dropped and a simultaneous pop is ignored. in_ready_o is unaffected in the flush cycle.
- Reset (async, any time including mid-transfer): count=0, all entry registers 0. Outputs immediately become out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=0, illegal_o=0, tag_o=0.
- Illegal instructions are enqueued like any other; no stall or exception is raised inside the block.

Test Plan:
- Reset, then addi x1,x0,-1 (0xFFF00093), tag 0x100, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, tag_o=0x100.
- Branch 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, fmt=3. jal 0x0080006F -> imm=0x00000008, fmt=5. sw 0x00112623 -> imm=0x0000000C, fmt=2.
- XLEN=64: srai 0x43F0D093 -> fmt=6, imm=0x3F. lui 0x800000B7 -> imm=0xFFFFFFFF80000000. With XLEN=32, opcode 0x1B (OP-IMM-32) -> illegal=1, imm=0.
- Backpressure: out_ready=0, push 3 back-to-back -> first 2 accepted, in_ready=0 on third. Raise out_ready -> entries emerge in order with correct tags.
- Full FIFO + flush_i with in_valid=1 -> next cycle out_valid=0, count 0, pushed item lost. Async rst_n low mid-stream -> outputs zero immediately.
- Random instruction stream vs reference model under random in_valid/out_ready -> bit-exact imm/fmt/illegal/tag, no loss or duplication.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator. Decodes every immediate format
// and queues the result with a caller tag in a 2-entry skid FIFO.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSRZ  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } ent_t;

    localparam bit RV64 = (XLEN == 64);

    logic [4:0]         w_opc;
    logic [2:0]         w_f3;
    logic               w_sh_f3;
    logic signed [31:0] w_val;
    fmt_e               w_fmt;
    logic               w_ill;
    ent_t               w_new;

    assign w_opc   = instr_i[6:2];
    assign w_f3    = instr_i[14:12];
    assign w_sh_f3 = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // All formats fit in 32 signed bits; zero-extended ones keep bit 31 clear,
    // so a single signed widening to XLEN covers both extension kinds.
    always_comb begin
        w_fmt = FMT_NONE;
        w_ill = 1'b0;
        w_val = '0;
        if (instr_i[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_opc)
                5'b00000, 5'b00011, 5'b11001: begin
                    w_fmt = FMT_I;
                    w_val = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                5'b00100: begin
                    if (w_sh_f3) begin
                        w_fmt = FMT_SHAMT;
                        w_val = RV64 ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
                    end else begin
                        w_fmt = FMT_I;
                        w_val = {{20{instr_i[31]}}, instr_i[31:20]};
                    end
                end
                5'b00110: begin
                    if (!RV64) begin
                        w_ill = 1'b1;
                    end else if (w_sh_f3) begin
                        w_fmt = FMT_SHAMT;
                        w_val = {27'b0, instr_i[24:20]};
                    end else begin
                        w_fmt = FMT_I;
                        w_val = {{20{instr_i[31]}}, instr_i[31:20]};
                    end
                end
                5'b01000: begin
                    w_fmt = FMT_S;
                    w_val = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                end
                5'b11000: begin
                    w_fmt = FMT_B;
                    w_val = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                             instr_i[11:8], 1'b0};
                end
                5'b00101, 5'b01101: begin
                    w_fmt = FMT_U;
                    w_val = {instr_i[31:12], 12'b0};
                end
                5'b11011: begin
                    w_fmt = FMT_J;
                    w_val = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                             instr_i[30:21], 1'b0};
                end
                5'b11100: begin
                    if (w_f3[2]) begin
                        w_fmt = FMT_CSRZ;
                        w_val = {27'b0, instr_i[19:15]};
                    end else if (w_f3 != 3'b000) begin
                        // CSR address is unsigned
                        w_fmt = FMT_I;
                        w_val = {20'b0, instr_i[31:20]};
                    end
                end
                5'b01100: ;
                5'b01110: w_ill = !RV64;
                default:  w_ill = 1'b1;
            endcase
        end
    end

    assign w_new.imm = XLEN'(w_val);
    assign w_new.fmt = w_fmt;
    assign w_new.ill = w_ill;
    assign w_new.tag = tag_i;

    logic [1:0] r_count;
    ent_t       r_head;
    ent_t       r_tail;
    logic       w_push;
    logic       w_pop;

    assign in_ready_o  = (r_count != 2'd2);
    assign out_valid_o = (r_count != 2'd0);
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    // Two-register skid: head always feeds the outputs, tail only holds the
    // second entry while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush_i) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= w_new;
                    else                 r_tail <= w_new;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11:   r_head <= w_new;
                default: ;
            endcase
        end
    end

    assign imm_o     = r_head.imm;
    assign fmt_o     = r_head.fmt;
    assign illegal_o = r_head.ill;
    assign tag_o     = r_head.tag;

endmodule
